time_counter: RTL
=================

// Module: time_counter
// PURPOSE
//  Timekeeping core of the digital clock. Derives a 1 Hz tick from the system
//  clock and keeps hours:minutes:seconds as binary values (0-23 / 0-59 / 0-59).
//  Has a small set-mode FSM for adjusting the time from two pushbuttons.
//  Feeds the tens/ones digit splitter stage. One splitter per field: sec_o, min_o, hour_o.
// PARAMETERS
//  CLK_HZ    50_000_000  system clock cycles per 1 Hz tick (>=2)
//  HOUR_MAX  24          hour modulus (hour_o counts 0..HOUR_MAX-1, max 60)
// PORTS
//  clk       in   1  system clock, rising edge
//  rst       in   1  reset, asynchronous, active-high
//  en        in   1  run enable; 0 freezes prescaler and time in RUN
//  mode_btn  in   1  single-cycle pulse, debounced/synchronised upstream
//  inc_btn   in   1  single-cycle pulse, debounced/synchronised upstream
//  sec_o     out  6  seconds 0-59, registered
//  min_o     out  6  minutes 0-59, registered
//  hour_o    out  6  hours 0..HOUR_MAX-1, registered
//  state_o   out  2  FSM state: 0=RUN 1=SET_HR 2=SET_MIN
//  tick_o    out  1  high for exactly one cycle per 1 Hz tick
// BEHAVIOUR
//  - Reset (async, any time, mid-operation): sec/min/hour=0, state RUN,
//    prescaler=0, tick_o=0; outputs change without waiting for a clock edge.
//  - Prescaler counts 0..CLK_HZ-1 in RUN with en=1. On the edge where it is at
//    CLK_HZ-1 it returns to 0 and seconds advance. New sec_o is visible in the
//    cycle after that edge. tick_o is high in that same cycle.
//  - Cascade: sec 59->0 carries min+1. min 59->0 carries hour+1.
//    hour HOUR_MAX-1->0. 23:59:59 -> 00:00:00 in one tick.
//  - FSM, mode_btn advances: RUN->SET_HR->SET_MIN->RUN. State 3 unreachable;
//    if ever entered, next edge goes to RUN.
//  - SET_HR / SET_MIN: prescaler held at 0, no ticks, tick_o=0, en ignored.
//  - inc_btn in SET_HR: hour+1, wraps HOUR_MAX-1->0, no other field touched.
//  - inc_btn in SET_MIN: min+1, wraps 59->0, no carry into hour.
//  - inc_btn in RUN: ignored.
//  - SET_MIN->RUN transition: sec cleared to 0, prescaler restarts from 0.
//    First tick occurs CLK_HZ cycles after the transition edge.
//  - mode_btn and inc_btn in the same cycle: mode wins, inc dropped.
//  - en=0 in RUN: time and prescaler hold; mode_btn still accepted.
//  - All outputs always within range; no value >59 is ever presented downstream.
// CONFIGURATION
//  ALARM_EN defined: adds ports alarm_hr in 6, alarm_min in 6, alarm_o out 1.
//    - alarm_o is registered. It is high while state is RUN and
//      hour_o==alarm_hr and min_o==alarm_min.
//    - alarm_o has 1-cycle latency after the match begins. It is 0 in SET states
//      and 0 at reset.
//    - An out-of-range alarm_hr/alarm_min never matches.
//  ALARM_EN undefined: those ports and the compare logic do not exist; all
//    other behaviour is identical.
// TESTING (CLK_HZ=4, HOUR_MAX=24)
//  1. rst, then en=1 for 240 cycles -> 60 tick_o pulses, exactly 4 cycles
//     apart; final min_o=1, sec_o=0, hour_o=0.
//  2. Set the time to 23:59 via mode + 23 inc + mode + 59 inc + mode, then run
//     240 cycles -> 00:00:00.
//     One cycle earlier, it reads 23:59:59.
//  3. SET_MIN with min=59, inc pulse -> min=0, hour unchanged.
//     In SET_HR with hour=23, inc pulse -> hour=0.
//  4. SET_HR with hour=5, mode_btn and inc_btn in the same cycle ->
//     state_o=2, hour stays 5.
//  5. RUN at 00:00:37, en=0 for 20 cycles -> sec stays 37, no tick_o.
//     Then rst pulse between edges -> all outputs 0 before the next edge,
//     state_o=0.
//  6. ALARM_EN with alarm 00:01, run from reset -> alarm_o rises one cycle
//     after min_o becomes 1.
//     alarm_o falls one cycle after min_o becomes 2.
//     mode_btn pressed during the match -> alarm_o=0 next cycle.

Source files
------------

// File: rtl/time_counter.sv
// Timekeeping core: 1 Hz prescaler, hh:mm:ss counters and a RUN/SET_HR/SET_MIN set-mode FSM.
// Optional alarm compare is built when the ALARM_EN macro is defined.
module time_counter #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_btn,
  input  logic       inc_btn,
`ifdef ALARM_EN
  input  logic [5:0] alarm_hr,
  input  logic [5:0] alarm_min,
  output logic       alarm_o,
`endif
  output logic [5:0] sec_o,
  output logic [5:0] min_o,
  output logic [5:0] hour_o,
  output logic [1:0] state_o,
  output logic       tick_o
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);
  localparam logic [5:0]    HOUR_TOP  = 6'(HOUR_MAX - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      presc  <= '0;
      sec_o  <= '0;
      min_o  <= '0;
      hour_o <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      case (state)
        RUN: begin
          // A mode press takes priority over a tick landing on the same edge.
          if (mode_btn) begin
            state <= SET_HR;
            presc <= '0;
          end else if (en) begin
            if (presc == PRESC_TOP) begin
              presc  <= '0;
              tick_o <= 1'b1;
              if (sec_o == 6'd59) begin
                sec_o <= '0;
                if (min_o == 6'd59) begin
                  min_o  <= '0;
                  hour_o <= (hour_o == HOUR_TOP) ? 6'd0 : hour_o + 6'd1;
                end else begin
                  min_o <= min_o + 6'd1;
                end
              end else begin
                sec_o <= sec_o + 6'd1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        SET_HR: begin
          presc <= '0;
          if (mode_btn) begin
            state <= SET_MIN;
          end else if (inc_btn) begin
            hour_o <= (hour_o == HOUR_TOP) ? 6'd0 : hour_o + 6'd1;
          end
        end
        SET_MIN: begin
          presc <= '0;
          if (mode_btn) begin
            state <= RUN;
            sec_o <= '0;
          end else if (inc_btn) begin
            min_o <= (min_o == 6'd59) ? 6'd0 : min_o + 6'd1;
          end
        end
        default: begin
          state <= RUN;
          presc <= '0;
        end
      endcase
    end
  end

`ifdef ALARM_EN
  // Gating on mode_btn keeps alarm_o low in the first SET_HR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_o <= 1'b0;
    end else begin
      alarm_o <= (state == RUN) && !mode_btn &&
                 (alarm_hr < 6'(HOUR_MAX)) && (alarm_min < 6'd60) &&
                 (alarm_hr == hour_o) && (alarm_min == min_o);
    end
  end
`endif

endmodule
